uart_rx_8n1: RTL and testbench



---
 rtl/uart_rx_8n1_if.sv | 28 ++
 rtl/uart_rx_8n1.sv | 175 +++++++++++++++++
 tb/tb_uart_rx_8n1.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_8n1_if.sv
// Serial-receiver signal bundle: the line into the receiver and the byte/strobe/status outputs.
// master drives the line and consumes results; slave is the receiver itself.
interface uart_rx_8n1_if;
    logic       uart_rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       rx_busy;

    modport master (
        output uart_rxd,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  parity_err,
        input  rx_busy
    );

    modport slave (
        input  uart_rxd,
        output rx_data,
        output rx_valid,
        output frame_err,
        output parity_err,
        output rx_busy
    );
endinterface

// File: rtl/uart_rx_8n1.sv
// UART receiver, 8 data bits LSB first, 1 start / 1 stop; define UART_RX_PARITY_EN for 8E1.
// Latency: strobe ~9.5 bit periods + 3 clocks after the start edge; no backpressure, byte must be taken on rx_valid.
// Backpressure: none; a new byte overwrites rx_data.
module uart_rx_8n1 #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic          clk_50M,
    input  logic          reset,
    uart_rx_8n1_if.slave  rx_if
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_MID  = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_sync;
    logic [CW-1:0]   r_baud_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic [7:0]      r_rx_data;
    logic            r_rx_valid;
    logic            r_frame_err;

    logic            w_rxs;
    logic            w_tick;
    logic            w_mid;
    logic            w_cnt_clr;
    logic            w_shift_en;
    logic            w_valid_set;
    logic            w_ferr_set;

`ifdef UART_RX_PARITY_EN
    logic            r_par_bad;
    logic            r_parity_err;
    logic            w_par_en;
    logic            w_perr_set;
`endif

    assign w_rxs  = r_sync[1];
    assign w_tick = (r_baud_cnt == C_LAST);
    assign w_mid  = (r_baud_cnt == C_MID);

    // State register
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; the stop bit is judged at its midpoint so IDLE is back
    // in time for a start edge that immediately follows it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_rxs) w_state_nxt = S_START;
            end
            S_START: begin
                if (w_mid) w_state_nxt = w_rxs ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_tick && (r_bit_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_tick) w_state_nxt = S_STOP;
            end
`endif
            S_STOP: begin
                if (w_tick) w_state_nxt = w_rxs ? S_IDLE : S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (w_rxs) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        w_cnt_clr   = (w_state_nxt != r_state)
                   || (r_state == S_IDLE)
                   || (r_state == S_WAIT_IDLE)
                   || ((r_state == S_DATA) && w_tick);
        w_shift_en  = (r_state == S_DATA) && w_tick;
        w_valid_set = (r_state == S_STOP) && w_tick && w_rxs;
        w_ferr_set  = (r_state == S_STOP) && w_tick && !w_rxs;
`ifdef UART_RX_PARITY_EN
        w_par_en    = (r_state == S_PARITY) && w_tick;
        w_perr_set  = w_valid_set && r_par_bad;
`endif
    end

    // Datapath: synchronizer, baud counter, shift register, output strobes
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            r_sync      <= 2'b11;
            r_baud_cnt  <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], rx_if.uart_rxd};

            if (w_cnt_clr) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + 1'b1;
            end

            if (r_state != S_DATA) begin
                r_bit_idx <= 3'd0;
            end else if (w_shift_en) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end

            if (w_shift_en) begin
                r_shift[r_bit_idx] <= w_rxs;
            end

            r_rx_valid  <= w_valid_set;
            r_frame_err <= w_ferr_set;
            if (w_valid_set) begin
                r_rx_data <= r_shift;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: the parity bit makes the 9-bit XOR zero.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (w_par_en) begin
                r_par_bad <= (w_rxs != (^r_shift));
            end
            r_parity_err <= w_perr_set;
        end
    end

    assign rx_if.parity_err = r_parity_err;
`else
    assign rx_if.parity_err = 1'b0;
`endif

    assign rx_if.rx_data   = r_rx_data;
    assign rx_if.rx_valid  = r_rx_valid;
    assign rx_if.frame_err = r_frame_err;
    assign rx_if.rx_busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Bench for uart_rx_8n1 at a shortened bit time (16 clocks per bit); bit-banged
// frames push expected bytes to a scoreboard, a monitor collects strobes.
module tb_uart_rx_8n1;
    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 3_125_000;
    localparam int CPB      = CLK_FREQ / BAUD;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    uart_rx_8n1_if rx_if ();

    uart_rx_8n1 #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk_50M (clk),
        .reset   (rst),
        .rx_if   (rx_if.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // {parity_err, data}
    logic [8:0] exp_q[$];
    logic [8:0] obs_q[$];
    int         ferr_cnt;
    int         perr_cnt;
    bit         bad_shape;
    logic       prev_vld;
    logic       prev_ferr;
    logic [7:0] last_good;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_if.rx_valid) obs_q.push_back({rx_if.parity_err, rx_if.rx_data});
            if (rx_if.frame_err) ferr_cnt++;
            if (rx_if.parity_err) perr_cnt++;
            if ((rx_if.rx_valid && prev_vld) || (rx_if.frame_err && prev_ferr)) bad_shape = 1'b1;
            if (rx_if.frame_err && (rx_if.rx_valid || rx_if.parity_err)) bad_shape = 1'b1;
            if (rx_if.parity_err && !rx_if.rx_valid) bad_shape = 1'b1;
        end
        prev_vld  = rx_if.rx_valid;
        prev_ferr = rx_if.frame_err;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit);
        rx_if.uart_rxd = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_if.uart_rxd = d[i];
            wait_clks(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rx_if.uart_rxd = par_bit;
        wait_clks(CPB);
`else
        if (par_bit === 1'bx) rx_if.uart_rxd = 1'b1;
`endif
        rx_if.uart_rxd = stop_bit;
        wait_clks(CPB);
    endtask

    task automatic send_good(input logic [7:0] d);
        exp_q.push_back({1'b0, d});
        send_frame(d, 1'b1, ^d);
        last_good = d;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx_if.uart_rxd = 1'b1;
        wait_clks(3);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (rx_if.rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data got %h want 00", rx_if.rx_data); end
        n_checks++; if (rx_if.rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid got %b want 0", rx_if.rx_valid); end
        n_checks++; if (rx_if.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got %b want 0", rx_if.frame_err); end
        n_checks++; if (rx_if.parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err got %b want 0", rx_if.parity_err); end
        n_checks++; if (rx_if.rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_rx_busy got %b want 0", rx_if.rx_busy); end
        wait_clks(400);
        n_checks++; if ((obs_q.size() + ferr_cnt) !== 0) begin n_fail++; $display("FAIL idle_no_strobe got %0d strobes want 0", obs_q.size() + ferr_cnt); end
        n_checks++; if (rx_if.rx_busy !== 1'b0) begin n_fail++; $display("FAIL idle_rx_busy got %b want 0", rx_if.rx_busy); end
    endtask

    task automatic test_loopback;
        send_good(8'h12);
        send_good(8'h34);
        send_good(8'h56);
        wait_clks(CPB);
        n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL loopback_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [8:0] e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL loopback_byte got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        n_checks++; if (ferr_cnt !== 0) begin n_fail++; $display("FAIL loopback_frame_err got %0d want 0", ferr_cnt); end
    endtask

    task automatic test_back_to_back;
        send_good(8'h00);
        send_good(8'hFF);
        send_good(8'h5A);
        wait_clks(CPB);
        n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [8:0] e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL b2b_byte got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_glitch;
        rx_if.uart_rxd = 1'b0;
        wait_clks(4);
        n_checks++; if (rx_if.rx_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_rise got %b want 1", rx_if.rx_busy); end
        rx_if.uart_rxd = 1'b1;
        wait_clks(CPB / 2 + 2);
        n_checks++; if (rx_if.rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_drop got %b want 0", rx_if.rx_busy); end
        wait_clks(2 * CPB);
        n_checks++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL glitch_no_valid got %0d want 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_frame_err;
        int ferr0;
        ferr0 = ferr_cnt;
        send_frame(8'hA5, 1'b0, ^(8'hA5));
        wait_clks(2 * CPB);
        n_checks++; if (rx_if.rx_busy !== 1'b1) begin n_fail++; $display("FAIL ferr_wait_busy got %b want 1", rx_if.rx_busy); end
        rx_if.uart_rxd = 1'b1;
        wait_clks(CPB);
        n_checks++; if (ferr_cnt - ferr0 !== 1) begin n_fail++; $display("FAIL ferr_pulses got %0d want 1", ferr_cnt - ferr0); end
        n_checks++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL ferr_no_valid got %0d want 0", obs_q.size()); end
        n_checks++; if (rx_if.rx_data !== last_good) begin n_fail++; $display("FAIL ferr_data_kept got %h want %h", rx_if.rx_data, last_good); end
        n_checks++; if (rx_if.rx_busy !== 1'b0) begin n_fail++; $display("FAIL ferr_back_idle got %b want 0", rx_if.rx_busy); end
        obs_q.delete();
        send_good(8'h3C);
        wait_clks(CPB);
        n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL after_ferr_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [8:0] e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL after_ferr_byte got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid;
        rx_if.uart_rxd = 1'b0;
        wait_clks(CPB);
        rx_if.uart_rxd = 1'b1;
        wait_clks(4 * CPB + CPB / 2);
        rst = 1'b1;
        wait_clks(2);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (rx_if.rx_busy !== 1'b0) begin n_fail++; $display("FAIL midreset_idle got %b want 0", rx_if.rx_busy); end
        n_checks++; if (rx_if.rx_data !== 8'h00) begin n_fail++; $display("FAIL midreset_data got %h want 00", rx_if.rx_data); end
        wait_clks(5 * CPB);
        n_checks++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL midreset_no_strobe got %0d want 0", obs_q.size()); end
        obs_q.delete();
        send_good(8'h81);
        wait_clks(CPB);
        n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL midreset_next_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [8:0] e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL midreset_next_byte got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_parity;
`ifdef UART_RX_PARITY_EN
        exp_q.push_back({1'b1, 8'h07});
        send_frame(8'h07, 1'b1, 1'b0);
        exp_q.push_back({1'b0, 8'h03});
        send_frame(8'h03, 1'b1, 1'b0);
        wait_clks(CPB);
        n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL parity_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [8:0] e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL parity_byte got {perr,data}=%h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
`else
        n_checks++; if (perr_cnt !== 0) begin n_fail++; $display("FAIL parity_absent got %0d pulses want 0", perr_cnt); end
`endif
    endtask

    task automatic test_strobe_shape;
        n_checks++; if (bad_shape !== 1'b0) begin n_fail++; $display("FAIL strobe_shape got %b want 0", bad_shape); end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        ferr_cnt = 0; perr_cnt = 0;
        bad_shape = 1'b0;
        prev_vld = 1'b0; prev_ferr = 1'b0;
        last_good = 8'h00;
        rst = 1'b1;
        rx_if.uart_rxd = 1'b1;
        test_reset();
        test_loopback();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_parity();
        test_strobe_shape();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule
